// File: rtl/matrix_summary_reporter.sv
// rtl/matrix_summary_reporter.sv - two-pass size-table scanner with UART report and random size pick
module matrix_summary_reporter #(
  parameter int MAX_SIZE  = 5,
  parameter int CNT_WIDTH = 5,
  parameter int RD_LAT    = 2,
  parameter int TOT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_req,
  input  logic [1:0]           mode,
  input  logic [7:0]           rand_in,
  output logic                 busy,
  output logic                 done,
  input  logic                 uart_tx_busy,
  output logic                 uart_tx_start,
  output logic [7:0]           uart_tx_data,
  output logic [2:0]           qry_row,
  output logic [2:0]           qry_col,
  input  logic [CNT_WIDTH-1:0] qry_cnt,
  output logic [TOT_WIDTH-1:0] total_cnt,
  output logic [4:0]           kind_cnt,
  output logic                 sel_valid,
  output logic [2:0]           sel_row,
  output logic [2:0]           sel_col,
  output logic [CNT_WIDTH-1:0] sel_cnt
);

  localparam logic [2:0]  LP_MAX      = 3'(MAX_SIZE);
  localparam logic [15:0] LP_LAT_LAST = 16'(RD_LAT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_P1_ADDR, S_P1_WAIT, S_P1_ACC, S_MOD, S_DEC, S_EMIT,
    S_TX_START, S_TX_WAIT_HI, S_TX_WAIT_LO,
    S_P2_ADDR, S_P2_WAIT, S_P2_ACC, S_P2_NEXT, S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;

  logic [1:0]             r_mode;
  logic [7:0]             r_target;
  logic [7:0]             r_k;
  logic [15:0]            r_wait;
  logic [2:0]             r_qry_row;
  logic [2:0]             r_qry_col;
  logic [TOT_WIDTH-1:0]   r_acc_tot;
  logic [4:0]             r_acc_kind;
  logic [TOT_WIDTH-1:0]   r_total;
  logic [4:0]             r_kind;
  logic                   r_sel_valid;
  logic [2:0]             r_sel_row;
  logic [2:0]             r_sel_col;
  logic [CNT_WIDTH-1:0]   r_sel_cnt;
  logic [13:0]            r_dec_val;
  logic [1:0]             r_dec_pow;
  logic [3:0]             r_dec_dig;
  logic                   r_dec_started;
  logic [7:0]             r_buf [0:15];
  logic [3:0]             r_len;
  logic [3:0]             r_idx;
  logic                   r_phase_line;
  logic [7:0]             r_tx_data;

  logic                   w_last_addr;
  logic                   w_col_wrap;
  logic [2:0]             w_adv_row;
  logic [2:0]             w_adv_col;
  logic                   w_nonzero;
  logic                   w_lat_one;
  logic                   w_wait_done;
  logic                   w_mod_exit;
  logic                   w_dec_last;
  logic                   w_emit_done;
  logic                   w_sel_hit;
  logic [13:0]            w_pow;

  assign w_col_wrap  = (r_qry_col == LP_MAX);
  assign w_last_addr = w_col_wrap && (r_qry_row == LP_MAX);
  assign w_adv_row   = w_col_wrap ? r_qry_row + 3'd1 : r_qry_row;
  assign w_adv_col   = w_col_wrap ? 3'd1 : r_qry_col + 3'd1;
  assign w_nonzero   = (qry_cnt != '0);
  assign w_lat_one   = (LP_LAT_LAST == 16'd0);
  assign w_wait_done = (r_wait == LP_LAT_LAST);
  assign w_mod_exit  = (r_kind == 5'd0) || (r_target < {3'd0, r_kind});
  assign w_dec_last  = (r_dec_pow == 2'd3);
  assign w_emit_done = (r_idx == r_len);
  assign w_sel_hit   = w_nonzero && (r_k == r_target);
  assign w_pow       = (r_dec_pow == 2'd0) ? 14'd1000 :
                       (r_dec_pow == 2'd1) ? 14'd100  : 14'd10;

  assign qry_row      = r_qry_row;
  assign qry_col      = r_qry_col;
  assign total_cnt    = r_total;
  assign kind_cnt     = r_kind;
  assign sel_valid    = r_sel_valid;
  assign sel_row      = r_sel_row;
  assign sel_col      = r_sel_col;
  assign sel_cnt      = r_sel_cnt;
  assign uart_tx_data = r_tx_data;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state: two address walks with a shared byte-emission path
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (start_req) w_next = S_P1_ADDR;
      S_P1_ADDR:    w_next = w_lat_one ? S_P1_ACC : S_P1_WAIT;
      S_P1_WAIT:    if (w_wait_done) w_next = S_P1_ACC;
      S_P1_ACC:     w_next = w_last_addr ? S_MOD : S_P1_ADDR;
      S_MOD:        if (w_mod_exit) w_next = (r_mode == 2'd2) ? S_P2_ADDR : S_DEC;
      S_DEC:        if (w_dec_last) w_next = S_EMIT;
      S_EMIT: begin
        if (!w_emit_done)     w_next = S_TX_START;
        else if (r_phase_line) w_next = S_P2_NEXT;
        else                  w_next = (r_mode == 2'd1) ? S_DONE : S_P2_ADDR;
      end
      S_TX_START:   w_next = S_TX_WAIT_HI;
      S_TX_WAIT_HI: if (uart_tx_busy) w_next = S_TX_WAIT_LO;
      S_TX_WAIT_LO: if (!uart_tx_busy) w_next = S_EMIT;
      S_P2_ADDR:    w_next = w_lat_one ? S_P2_ACC : S_P2_WAIT;
      S_P2_WAIT:    if (w_wait_done) w_next = S_P2_ACC;
      S_P2_ACC:     w_next = (w_nonzero && r_mode == 2'd0) ? S_DEC : S_P2_NEXT;
      S_P2_NEXT:    w_next = w_last_addr ? S_DONE : S_P2_ADDR;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    uart_tx_start = 1'b0;
    case (r_state)
      S_IDLE:     ;
      S_DONE:     done = 1'b1;
      S_TX_START: begin
        busy          = 1'b1;
        uart_tx_start = 1'b1;
      end
      default:    busy = 1'b1;
    endcase
  end

  // datapath: accumulators, modulo, decimal conversion, byte buffer, selection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode        <= 2'd0;
      r_target      <= 8'd0;
      r_k           <= 8'd0;
      r_wait        <= 16'd0;
      r_qry_row     <= 3'd1;
      r_qry_col     <= 3'd1;
      r_acc_tot     <= '0;
      r_acc_kind    <= 5'd0;
      r_total       <= '0;
      r_kind        <= 5'd0;
      r_sel_valid   <= 1'b0;
      r_sel_row     <= 3'd0;
      r_sel_col     <= 3'd0;
      r_sel_cnt     <= '0;
      r_dec_val     <= 14'd0;
      r_dec_pow     <= 2'd0;
      r_dec_dig     <= 4'd0;
      r_dec_started <= 1'b0;
      r_len         <= 4'd0;
      r_idx         <= 4'd0;
      r_phase_line  <= 1'b0;
      r_tx_data     <= 8'd0;
      for (int i = 0; i < 16; i++) r_buf[i] <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_req) begin
            r_mode      <= (mode == 2'd3) ? 2'd0 : mode;
            r_target    <= rand_in;
            r_k         <= 8'd0;
            r_acc_tot   <= '0;
            r_acc_kind  <= 5'd0;
            r_sel_valid <= 1'b0;
            r_sel_row   <= 3'd0;
            r_sel_col   <= 3'd0;
            r_sel_cnt   <= '0;
            r_qry_row   <= 3'd1;
            r_qry_col   <= 3'd1;
          end
        end
        S_P1_ADDR, S_P2_ADDR: r_wait <= 16'd1;
        S_P1_WAIT, S_P2_WAIT: r_wait <= r_wait + 16'd1;
        S_P1_ACC: begin
          r_acc_tot  <= r_acc_tot + TOT_WIDTH'(qry_cnt);
          r_acc_kind <= r_acc_kind + {4'd0, w_nonzero};
          if (w_last_addr) begin
            r_total   <= r_acc_tot + TOT_WIDTH'(qry_cnt);
            r_kind    <= r_acc_kind + {4'd0, w_nonzero};
            r_qry_row <= 3'd1;
            r_qry_col <= 3'd1;
          end else begin
            r_qry_row <= w_adv_row;
            r_qry_col <= w_adv_col;
          end
        end
        S_MOD: begin
          if (!w_mod_exit) begin
            r_target <= r_target - {3'd0, r_kind};
          end else begin
            r_dec_val     <= 14'(r_total);
            r_dec_pow     <= 2'd0;
            r_dec_dig     <= 4'd0;
            r_dec_started <= 1'b0;
            r_len         <= 4'd0;
            r_idx         <= 4'd0;
            r_phase_line  <= 1'b0;
          end
        end
        S_DEC: begin
          if (!w_dec_last) begin
            if (r_dec_val >= w_pow) begin
              r_dec_val <= r_dec_val - w_pow;
              r_dec_dig <= r_dec_dig + 4'd1;
            end else begin
              if (r_dec_dig != 4'd0 || r_dec_started) begin
                r_buf[r_len]  <= 8'h30 + {4'd0, r_dec_dig};
                r_len         <= r_len + 4'd1;
                r_dec_started <= 1'b1;
              end
              r_dec_dig <= 4'd0;
              r_dec_pow <= r_dec_pow + 2'd1;
            end
          end else begin
            // units digit is always emitted so a zero value still prints "0"
            r_buf[r_len]        <= 8'h30 + {4'd0, r_dec_val[3:0]};
            r_buf[r_len + 4'd1] <= 8'h0A;
            r_len               <= r_len + 4'd2;
          end
        end
        S_EMIT: begin
          if (!w_emit_done) r_tx_data <= r_buf[r_idx];
        end
        S_TX_WAIT_LO: begin
          if (!uart_tx_busy) r_idx <= r_idx + 4'd1;
        end
        S_P2_ACC: begin
          if (w_nonzero) begin
            if (w_sel_hit) begin
              r_sel_valid <= 1'b1;
              r_sel_row   <= r_qry_row;
              r_sel_col   <= r_qry_col;
              r_sel_cnt   <= qry_cnt;
            end
            r_k <= r_k + 8'd1;
            if (r_mode == 2'd0) begin
              r_buf[0]      <= 8'h30 + {5'd0, r_qry_row};
              r_buf[1]      <= 8'h78;
              r_buf[2]      <= 8'h30 + {5'd0, r_qry_col};
              r_buf[3]      <= 8'h3A;
              r_len         <= 4'd4;
              r_idx         <= 4'd0;
              r_phase_line  <= 1'b1;
              r_dec_val     <= 14'(qry_cnt);
              r_dec_pow     <= 2'd0;
              r_dec_dig     <= 4'd0;
              r_dec_started <= 1'b0;
            end
          end
        end
        S_P2_NEXT: begin
          if (w_last_addr) begin
            r_qry_row <= 3'd1;
            r_qry_col <= 3'd1;
          end else begin
            r_qry_row <= w_adv_row;
            r_qry_col <= w_adv_col;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_summary_reporter.sv
// tb/tb_matrix_summary_reporter.sv - randomized bench for matrix_summary_reporter against a string-level model
module tb_matrix_summary_reporter;

  localparam int MS = 5;
  localparam int CW = 5;
  localparam int RL = 3;
  localparam int TW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_req;
  logic [1:0]    mode;
  logic [7:0]    rand_in;
  logic          busy;
  logic          done;
  logic          uart_tx_busy;
  logic          uart_tx_start;
  logic [7:0]    uart_tx_data;
  logic [2:0]    qry_row;
  logic [2:0]    qry_col;
  logic [CW-1:0] qry_cnt;
  logic [TW-1:0] total_cnt;
  logic [4:0]    kind_cnt;
  logic          sel_valid;
  logic [2:0]    sel_row;
  logic [2:0]    sel_col;
  logic [CW-1:0] sel_cnt;

  matrix_summary_reporter #(
    .MAX_SIZE(MS), .CNT_WIDTH(CW), .RD_LAT(RL), .TOT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_req(start_req), .mode(mode), .rand_in(rand_in),
    .busy(busy), .done(done), .uart_tx_busy(uart_tx_busy), .uart_tx_start(uart_tx_start),
    .uart_tx_data(uart_tx_data), .qry_row(qry_row), .qry_col(qry_col), .qry_cnt(qry_cnt),
    .total_cnt(total_cnt), .kind_cnt(kind_cnt), .sel_valid(sel_valid),
    .sel_row(sel_row), .sel_col(sel_col), .sel_cnt(sel_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // storage: value valid only once the address has been stable for RL cycles, junk before
  int            mem [1:MS][1:MS];
  logic [5:0]    last_addr = 6'd0;
  int            stable = 0;
  logic [CW-1:0] junk = '1;

  always @(posedge clk) begin
    junk <= CW'($urandom_range(1, (1 << CW) - 1));
    if ({qry_row, qry_col} != last_addr) begin
      last_addr <= {qry_row, qry_col};
      stable    <= 1;
    end else if (stable < 1000) begin
      stable <= stable + 1;
    end
  end

  always_comb begin
    qry_cnt = junk;
    if (stable >= RL && qry_row >= 1 && qry_row <= MS && qry_col >= 1 && qry_col <= MS)
      qry_cnt = CW'(mem[qry_row][qry_col]);
  end

  // UART: busy for hold_cycles after each start, records bytes and protocol errors
  int          hold_cycles = 3;
  logic        in_frame;
  int          fcnt;
  logic [7:0]  cur;
  logic [7:0]  rx_q[$];
  int          overlap_err = 0;
  int          data_err = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      in_frame     <= 1'b0;
      uart_tx_busy <= 1'b0;
    end else if (uart_tx_start) begin
      if (in_frame) overlap_err <= overlap_err + 1;
      rx_q.push_back(uart_tx_data);
      cur          <= uart_tx_data;
      in_frame     <= 1'b1;
      uart_tx_busy <= 1'b1;
      fcnt         <= hold_cycles;
    end else if (in_frame) begin
      if (uart_tx_data != cur) data_err <= data_err + 1;
      if (fcnt <= 1) begin
        uart_tx_busy <= 1'b0;
        in_frame     <= 1'b0;
      end else begin
        fcnt <= fcnt - 1;
      end
    end
  end

  task automatic clear_mem();
    for (int r = 1; r <= MS; r++)
      for (int c = 1; c <= MS; c++) mem[r][c] = 0;
  endtask

  task automatic plan_mem();
    clear_mem();
    mem[1][1] = 3;
    mem[2][3] = 12;
    mem[5][5] = 1;
  endtask

  // reference: report text and selection straight from the table contents
  task automatic build_expect(input int md, input int rnd, output string exp_s,
                              output int e_tot, output int e_kind, output int e_sv,
                              output int e_sr, output int e_sc, output int e_scnt);
    int lr[$];
    int lc[$];
    int ln[$];
    int em;
    int t;
    e_tot = 0;
    for (int r = 1; r <= MS; r++)
      for (int c = 1; c <= MS; c++) begin
        e_tot += mem[r][c];
        if (mem[r][c] > 0) begin
          lr.push_back(r); lc.push_back(c); ln.push_back(mem[r][c]);
        end
      end
    e_kind = lr.size();
    em = (md == 3) ? 0 : md;
    exp_s = "";
    if (em != 2) exp_s = $sformatf("%0d\n", e_tot);
    if (em == 0)
      for (int i = 0; i < e_kind; i++)
        exp_s = {exp_s, $sformatf("%0dx%0d:%0d\n", lr[i], lc[i], ln[i])};
    e_sv = 0; e_sr = 0; e_sc = 0; e_scnt = 0;
    if (em != 1 && e_kind > 0) begin
      t = rnd % e_kind;
      e_sv = 1; e_sr = lr[t]; e_sc = lc[t]; e_scnt = ln[t];
    end
  endtask

  task automatic run_scan(input int md, input int rnd, input int hold, input bit glitch);
    string exp_s;
    int    e_tot, e_kind, e_sv, e_sr, e_sc, e_scnt;
    bit    seen;
    int    nb;
    build_expect(md, rnd, exp_s, e_tot, e_kind, e_sv, e_sr, e_sc, e_scnt);
    hold_cycles = hold;
    rx_q.delete();
    overlap_err = 0;
    data_err = 0;
    @(negedge clk);
    mode = md[1:0]; rand_in = rnd[7:0]; start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    check_eq("busy_after_start", busy, 1);
    seen = 0;
    for (int cyc = 0; cyc < 15000; cyc++) begin
      if (done) begin seen = 1; break; end
      if (glitch) begin
        start_req = 1'($urandom_range(0, 1));
        mode      = 2'($urandom);
        rand_in   = 8'($urandom);
      end
      @(negedge clk);
    end
    start_req = 1'b0;
    check_eq("done_seen", seen, 1);
    check_eq("busy_at_done", busy, 0);
    @(negedge clk);
    check_eq("done_one_cycle", done, 0);
    check_eq("busy_after_done", busy, 0);
    check_eq("total_cnt", total_cnt, e_tot);
    check_eq("kind_cnt", kind_cnt, e_kind);
    check_eq("sel_valid", sel_valid, e_sv);
    check_eq("sel_row", sel_row, e_sr);
    check_eq("sel_col", sel_col, e_sc);
    check_eq("sel_cnt", sel_cnt, e_scnt);
    check_eq("nbytes", rx_q.size(), exp_s.len());
    nb = (rx_q.size() < exp_s.len()) ? rx_q.size() : exp_s.len();
    for (int i = 0; i < nb; i++)
      check_eq($sformatf("byte%0d", i), rx_q[i], exp_s[i]);
    check_eq("uart_overlap", overlap_err, 0);
    check_eq("uart_data_hold", data_err, 0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; start_req = 1'b0; mode = 2'd0; rand_in = 8'd0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_tx_start", uart_tx_start, 0);
    check_eq("rst_tx_data", uart_tx_data, 0);
    check_eq("rst_qry_row", qry_row, 1);
    check_eq("rst_qry_col", qry_col, 1);
    check_eq("rst_total", total_cnt, 0);
    check_eq("rst_kind", kind_cnt, 0);
    check_eq("rst_sel_valid", sel_valid, 0);
    rst_n = 1'b1;

    run_scan(0, int'($urandom_range(0, 255)), 3, 0);

    plan_mem();
    run_scan(0, 4, 2, 0);
    run_scan(1, 4, 2, 0);
    run_scan(2, 4, 2, 0);
    run_scan(3, 9, 1, 0);

    for (int r = 1; r <= MS; r++)
      for (int c = 1; c <= MS; c++) mem[r][c] = 31;
    run_scan(0, 255, 1, 0);

    for (int n = 0; n < 5; n++) begin
      for (int r = 1; r <= MS; r++)
        for (int c = 1; c <= MS; c++)
          mem[r][c] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 31));
      run_scan(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
               int'($urandom_range(1, 4)), 1);
    end

    plan_mem();
    hold_cycles = 6;
    rx_q.delete();
    @(negedge clk);
    mode = 2'd0; rand_in = 8'd4; start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (rx_q.size() >= 4 && uart_tx_busy) begin seen = 1; break; end
      @(negedge clk);
    end
    check_eq("midbyte_reached", seen, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_tx_start", uart_tx_start, 0);
    check_eq("midrst_sel_valid", sel_valid, 0);
    check_eq("midrst_total", total_cnt, 0);
    @(negedge clk);
    check_eq("midrst_idle_tx", uart_tx_start, 0);
    check_eq("midrst_idle_busy", busy, 0);
    run_scan(0, 7, 2, 0);

    plan_mem();
    run_scan(0, 4, 50, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
